// File: rtl/radix2_seq_divider_pkg.sv
// Shared types and defaults for the radix-2 restoring divider.
package div_pkg;
   typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;
   localparam int DIV_WIDTH = 16;
endpackage

// File: rtl/radix2_seq_divider_if.sv
// Operand/result valid-ready bus of the sequential divider.
interface radix2_seq_divider_if
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
);
   logic                 in_valid;
   logic                 in_ready;
   logic [2*WIDTH-1:0]   dividend;
   logic [WIDTH-1:0]     divisor;
   logic                 out_valid;
   logic                 out_ready;
   logic [WIDTH-1:0]     quotient;
   logic [WIDTH-1:0]     remainder;
   logic                 div_by_zero;
   logic                 overflow;

   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
   );

   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
   );
endinterface

// File: rtl/radix2_seq_divider_step.sv
// One restoring-division iteration: shift {R,Q} left, trial subtract, restore on borrow.
module div_step
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH:0]   r_i,
   input  logic [WIDTH-1:0] q_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH:0]   r_o,
   output logic [WIDTH-1:0] q_o,
   output logic             qbit_o
);
   logic [WIDTH+1:0] r_sh;
   logic [WIDTH+1:0] trial;

   always_comb begin
      r_sh   = {r_i, q_i[WIDTH-1]};
      // Borrow out of the extra top bit means the trial went negative.
      trial  = r_sh - {2'b00, divisor_i};
      qbit_o = ~trial[WIDTH+1];
      r_o    = qbit_o ? trial[WIDTH:0] : r_sh[WIDTH:0];
      q_o    = {q_i[WIDTH-2:0], qbit_o};
   end
endmodule

// File: rtl/radix2_seq_divider.sv
// Sequential restoring divider: 2W/W -> W quotient and remainder, one bit per cycle.
module radix2_seq_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   radix2_seq_divider_if.slave  bus
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   div_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WIDTH:0]    r_q, r_d;
   logic [WIDTH-1:0]  q_q, q_d;
   logic [WIDTH-1:0]  dvs_q, dvs_d;
   logic [WIDTH-1:0]  quot_q, quot_d;
   logic [WIDTH-1:0]  rem_q, rem_d;
   logic              dbz_q, dbz_d;
   logic              ovf_q, ovf_d;

   logic [WIDTH:0]    st_r;
   logic [WIDTH-1:0]  st_q;
   logic              st_bit;
   logic [WIDTH-1:0]  hi, lo;

   div_step #(.WIDTH(WIDTH)) u_step (
      .r_i       (r_q),
      .q_i       (q_q),
      .divisor_i (dvs_q),
      .r_o       (st_r),
      .q_o       (st_q),
      .qbit_o    (st_bit)
   );

   assign hi = bus.dividend[2*WIDTH-1:WIDTH];
   assign lo = bus.dividend[WIDTH-1:0];

   assign bus.in_ready    = (state_q == IDLE);
   assign bus.out_valid   = (state_q == DONE);
   assign bus.quotient    = quot_q;
   assign bus.remainder   = rem_q;
   assign bus.div_by_zero = dbz_q;
   assign bus.overflow    = ovf_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         r_q     <= '0;
         q_q     <= '0;
         dvs_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         r_q     <= r_d;
         q_q     <= q_d;
         dvs_q   <= dvs_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      r_d     = r_q;
      q_d     = q_q;
      dvs_d   = dvs_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      ovf_d   = ovf_q;

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               dvs_d = bus.divisor;
               r_d   = {1'b0, hi};
               q_d   = lo;
               // Zero divisor wins over overflow; both skip the iteration entirely.
               if (bus.divisor == '0) begin
                  state_d = DONE;
                  quot_d  = '1;
                  rem_d   = lo;
                  dbz_d   = 1'b1;
                  ovf_d   = 1'b0;
               end else if (hi >= bus.divisor) begin
                  state_d = DONE;
                  quot_d  = '1;
                  rem_d   = '0;
                  dbz_d   = 1'b0;
                  ovf_d   = 1'b1;
               end else begin
                  state_d = CALC;
                  cnt_d   = CNT_W'(WIDTH);
               end
            end
         end
         CALC: begin
            r_d   = st_r;
            q_d   = {q_q[WIDTH-2:0], st_bit};
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = DONE;
               quot_d  = st_q;
               rem_d   = st_r[WIDTH-1:0];
               dbz_d   = 1'b0;
               ovf_d   = 1'b0;
            end
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_radix2_seq_divider.sv
// Vector table, random and corner sequences for radix2_seq_divider, checked via a result scoreboard.
module tb_radix2_seq_divider;
   import div_pkg::*;

   localparam int W = 16;

   typedef struct {
      logic [2*W-1:0] dd;
      logic [W-1:0]   dv;
      logic [W-1:0]   q;
      logic [W-1:0]   r;
      logic           dbz;
      logic           ovf;
   } vec_t;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dbz;
      logic         ovf;
      int           acc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   edge_cnt = 0;
   int   first_ov = 0;
   logic ov_prev = 1'b0;
   exp_t sb[$];
   exp_t m_e;
   vec_t vt[12];

   radix2_seq_divider_if #(.WIDTH(W)) bus ();

   radix2_seq_divider #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, edge_cnt);
      end
   endtask

   task automatic fail(input string nm);
      n_tests++;
      n_fail++;
      $display("FAIL %s: condition not met (edge %0d)", nm, edge_cnt);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2*W-1:0] dd, input logic [W-1:0] dv,
                       input logic [W-1:0] q, input logic [W-1:0] r,
                       input logic dbz, input logic ovf);
      int   n;
      exp_t e;
      bus.in_valid = 1'b1;
      bus.dividend = dd;
      bus.divisor  = dv;
      n = 0;
      while (!bus.in_ready && n < 200) begin
         tick();
         n++;
      end
      if (!bus.in_ready) fail("accept_timeout");
      else begin
         e.q = q; e.r = r; e.dbz = dbz; e.ovf = ovf;
         e.acc = edge_cnt + 1;
         sb.push_back(e);
      end
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         tick();
         n++;
      end
      if (sb.size() != 0) begin
         fail("drain_timeout");
         sb.delete();
      end
   endtask

   // Result monitor: samples on the falling edge, handshake happens at the next rising edge.
   always @(negedge clk) begin
      if (bus.out_valid && !ov_prev) first_ov = edge_cnt;
      ov_prev = bus.out_valid;
      if (rst_n && bus.out_valid) begin
         if (sb.size() == 0) fail("spurious_result");
         else if (bus.out_ready) begin
            m_e = sb.pop_front();
            chk("quotient", bus.quotient, m_e.q);
            chk("remainder", bus.remainder, m_e.r);
            chk("div_by_zero", bus.div_by_zero, m_e.dbz);
            chk("overflow", bus.overflow, m_e.ovf);
            chk("latency", first_ov - m_e.acc, (m_e.dbz | m_e.ovf) ? 0 : W);
         end else begin
            chk("hold_quotient", bus.quotient, sb[0].q);
            chk("hold_remainder", bus.remainder, sb[0].r);
            chk("hold_in_ready", bus.in_ready, 1'b0);
         end
      end
   end

   initial begin
      int acc;
      int n;
      logic [2*W-1:0] dd;
      logic [W-1:0]   dv, hi;

      vt[0]  = '{32'd100,       16'd7,      16'd14,     16'd2,      1'b0, 1'b0};
      vt[1]  = '{32'hFFFE0001,  16'hFFFF,   16'hFFFF,   16'h0000,   1'b0, 1'b0};
      vt[2]  = '{32'h00001234,  16'h0000,   16'hFFFF,   16'h1234,   1'b1, 1'b0};
      vt[3]  = '{32'h00070000,  16'd7,      16'hFFFF,   16'h0000,   1'b0, 1'b1};
      vt[4]  = '{32'h00000000,  16'd5,      16'h0000,   16'h0000,   1'b0, 1'b0};
      vt[5]  = '{32'h0000FFFF,  16'd1,      16'hFFFF,   16'h0000,   1'b0, 1'b0};
      vt[6]  = '{32'h0000FFFF,  16'd2,      16'h7FFF,   16'h0001,   1'b0, 1'b0};
      vt[7]  = '{32'hFFFF0000,  16'h0000,   16'hFFFF,   16'h0000,   1'b1, 1'b0};
      vt[8]  = '{32'h00010000,  16'd1,      16'hFFFF,   16'h0000,   1'b0, 1'b1};
      vt[9]  = '{32'h0000FFFF,  16'hFFFF,   16'h0001,   16'h0000,   1'b0, 1'b0};
      vt[10] = '{32'h00FFFFFF,  16'h0100,   16'hFFFF,   16'h00FF,   1'b0, 1'b0};
      vt[11] = '{32'd1000,      16'd10,     16'd100,    16'd0,      1'b0, 1'b0};

      bus.in_valid  = 1'b0;
      bus.dividend  = '0;
      bus.divisor   = '0;
      bus.out_ready = 1'b1;

      tick();
      tick();
      chk("rst_in_ready", bus.in_ready, 1'b1);
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_quotient", bus.quotient, '0);
      chk("rst_remainder", bus.remainder, '0);
      chk("rst_flags", {bus.div_by_zero, bus.overflow}, 2'b00);
      rst_n = 1'b1;
      tick();

      // Table vectors issued back to back.
      for (int i = 0; i < 12; i++)
         send(vt[i].dd, vt[i].dv, vt[i].q, vt[i].r, vt[i].dbz, vt[i].ovf);
      drain();

      // Random in-range operations against a behavioural model.
      for (int i = 0; i < 10; i++) begin
         dv = W'($urandom_range(1, 65535));
         hi = W'($urandom % dv);
         dd = {hi, W'($urandom)};
         send(dd, dv, W'(dd / {16'h0, dv}), W'(dd % {16'h0, dv}), 1'b0, 1'b0);
      end
      drain();

      // Backpressure: result held, second request only taken the cycle after handshake.
      bus.out_ready = 1'b0;
      send(32'd1000, 16'd10, 16'd100, 16'd0, 1'b0, 1'b0);
      n = 0;
      while (!bus.out_valid && n < 100) begin
         tick();
         n++;
      end
      if (!bus.out_valid) fail("bp_out_valid_timeout");
      bus.in_valid = 1'b1;
      bus.dividend = 32'd500;
      bus.divisor  = 16'd3;
      for (int i = 0; i < 5; i++) begin
         chk("bp_in_ready", bus.in_ready, 1'b0);
         tick();
      end
      chk("bp_out_valid_held", bus.out_valid, 1'b1);
      bus.out_ready = 1'b1;
      chk("hs_cycle_in_ready", bus.in_ready, 1'b0);
      tick();
      chk("post_hs_in_ready", bus.in_ready, 1'b1);
      chk("post_hs_out_valid", bus.out_valid, 1'b0);
      m_e.q = 16'd166; m_e.r = 16'd2; m_e.dbz = 1'b0; m_e.ovf = 1'b0;
      m_e.acc = edge_cnt + 1;
      sb.push_back(m_e);
      tick();
      bus.in_valid = 1'b0;
      drain();

      // Abort mid-calculation with reset, then rerun cleanly.
      bus.in_valid = 1'b1;
      bus.dividend = 32'd500;
      bus.divisor  = 16'd3;
      acc = edge_cnt + 1;
      chk("abort_accept_ready", bus.in_ready, 1'b1);
      tick();
      bus.in_valid = 1'b0;
      while (edge_cnt < acc + 7) tick();
      rst_n = 1'b0;
      tick();
      chk("abort_out_valid", bus.out_valid, 1'b0);
      chk("abort_in_ready", bus.in_ready, 1'b1);
      chk("abort_quotient", bus.quotient, '0);
      chk("abort_flags", {bus.div_by_zero, bus.overflow}, 2'b00);
      rst_n = 1'b1;
      tick();
      send(32'd500, 16'd3, 16'd166, 16'd2, 1'b0, 1'b0);
      drain();

      repeat (3) tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/radix2_seq_divider.md
# radix2_seq_divider

Sequential restoring divider that inverts the pipelined Wallace multiplier. It takes a 2·WIDTH-bit dividend (product width) and a WIDTH-bit divisor, and returns a WIDTH-bit quotient and remainder, resolving one quotient bit per cycle. It sits beside the multiplier in the arithmetic datapath. Both ends use valid/ready handshakes, so a multiplier result can be fed straight back in to recover an operand.

## Interface
Parameters:
- WIDTH, default 16: divisor, quotient and remainder width. The dividend is 2·WIDTH bits.

Ports:
- clk, input, 1: the single clock; all state updates on its rising edge.
- rst_n, input, 1: reset, synchronous and active-low.
- in_valid, input, 1: dividend/divisor presented.
- in_ready, output, 1: block can accept an operation.
- dividend, input, 2·WIDTH: numerator, unsigned.
- divisor, input, WIDTH: denominator, unsigned.
- out_valid, output, 1: result valid.
- out_ready, input, 1: consumer accepts the result.
- quotient, output, WIDTH: unsigned quotient.
- remainder, output, WIDTH: unsigned remainder.
- div_by_zero, output, 1: divisor was 0.
- overflow, output, 1: quotient not representable in WIDTH bits.

## Operation
- State machine states: IDLE, CALC, DONE.
- in_ready = (state == IDLE). out_valid = (state == DONE).
- Accept occurs when in_valid & in_ready. At accept, the operands are captured into internal registers and the exception checks are evaluated on the input ports:
  - divisor == 0 → DONE, quotient = all ones, remainder = dividend[WIDTH-1:0], div_by_zero = 1.
  - otherwise, if dividend[2W-1:W] ≥ divisor → DONE, quotient = all ones, remainder = 0, overflow = 1.
  - otherwise → CALC, with:
    - R (WIDTH+1 bits) = {0, dividend[2W-1:W]}
    - Q = dividend[W-1:0]
    - iteration counter = WIDTH.
- CALC performs one step per cycle:
  - {R,Q} shifts left by 1.
  - trial = R_shifted − {0,divisor}, computed at WIDTH+2 bits.
  - If trial ≥ 0: R = trial and Q[0] = 1. Otherwise R is restored and Q[0] = 0.
  - The counter decrements each step. The step taken with the counter at 1 is the last, and the state moves to DONE.
- DONE: quotient = Q, remainder = R[W-1:0], both flags 0 on a normal result. The outputs are held stable until out_valid & out_ready, then the state returns to IDLE.
- Invariant: R < divisor at every step, so R[W] = 0 in DONE.
- At most one flag is set at a time. div_by_zero takes priority over overflow.
- Backpressure: out_ready low holds DONE indefinitely with all outputs frozen. in_valid is ignored outside IDLE.

## Timing
- Reset values: in_ready = 1 (IDLE), out_valid = 0, quotient = 0, remainder = 0, div_by_zero = 0, overflow = 0. The counter, R and Q are also 0.
- Normal latency: with accept at edge T, out_valid is high from cycle T+WIDTH+1; for WIDTH = 16 that is T+17.
- Exception latency: out_valid is high in cycle T+1.
- Result handshake at cycle D → IDLE and in_ready = 1 at D+1. A new accept is possible at D+1 at the earliest, giving a throughput of one operation per WIDTH+2 cycles.
- rst_n low in any state, including mid-CALC or DONE, takes effect at the next edge. The operation is aborted, no result is emitted, and all outputs return to their reset values.
- Output registers change only on entry to DONE or on reset.

## Structure
- Package div_pkg holds:
  - typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t
  - localparam DIV_WIDTH = 16 as the shared default.
- Sub-module div_step is purely combinational and implements one restore iteration. Inputs are R, Q and divisor; outputs are the next R, the next Q and the quotient bit. The top instantiates it once and iterates it over time.
- The counter is $clog2(WIDTH+1) bits wide.

## Test plan
- dividend 32'd100, divisor 16'd7 → quotient 14, remainder 2, flags 0, out_valid exactly 17 cycles after accept.
- dividend 32'hFFFE0001, divisor 16'hFFFF → quotient 16'hFFFF, remainder 0, flags 0.
- dividend 32'h00001234, divisor 0 → out_valid next cycle, div_by_zero = 1, quotient 16'hFFFF, remainder 16'h1234.
- dividend 32'h00070000, divisor 16'd7 → out_valid next cycle, overflow = 1, quotient 16'hFFFF, remainder 0.
- Backpressure: 1000/10 with out_ready low for 5 cycles in DONE → outputs held at quotient 100, remainder 0. in_ready stays 0 and a second in_valid is not accepted until the cycle after the handshake.
- Abort: start 500/3, drive rst_n low at accept+8 → next cycle out_valid = 0 and in_ready = 1. Then 500/3 completes cleanly with quotient 166, remainder 2.
